// File: rtl/net_pkg.sv
// Shared NIC stream types and limiter state encoding.
package net_pkg;

    localparam int unsigned NET_DATA_W = 64;
    localparam int unsigned NET_KEEP_W = 8;
    localparam int unsigned NET_CNT_W  = 8;

    typedef struct packed {
        logic [NET_DATA_W-1:0] data;
        logic [NET_KEEP_W-1:0] keep;
        logic                  last;
    } net_flit_t;

    typedef struct packed {
        logic [NET_CNT_W-1:0] inc;
        logic [NET_CNT_W-1:0] period;
        logic [NET_CNT_W-1:0] size;
    } rlimit_cfg_t;

    typedef enum logic {
        StIdle,
        StInPkt
    } limiter_state_e;

endpackage

// File: rtl/net_token_bucket.sv
// Token bucket: refill timer plus a saturating token counter.
module net_token_bucket
    import net_pkg::*;
#(
    parameter int unsigned CNT_W = NET_CNT_W
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_inc,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_size,
    input  logic             i_consume,
    input  logic             i_hold,
    output logic             o_tokens_nonzero
);

    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_tokens;
    logic [CNT_W-1:0] w_tokens_next;
    logic [CNT_W:0]   w_sum;
    logic             w_refill;

    assign w_refill         = (r_period_cnt == i_period);
    assign o_tokens_nonzero = (r_tokens != '0);

    // One extra bit so tokens + inc cannot wrap before saturation.
    always_comb begin
        w_sum = {1'b0, r_tokens}
              + (w_refill ? {1'b0, i_inc} : '0)
              - {{CNT_W{1'b0}}, i_consume};
        if (i_hold) begin
            w_tokens_next = '0;
        end else if (w_sum > {1'b0, i_size}) begin
            w_tokens_next = i_size;
        end else begin
            w_tokens_next = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_period_cnt <= '0;
            r_tokens     <= '0;
        end else begin
            r_period_cnt <= w_refill ? '0 : r_period_cnt + 1'b1;
            r_tokens     <= w_tokens_next;
        end
    end

endmodule

// File: rtl/net_rate_limiter.sv
// Token-bucket rate limiter for a valid/ready flit stream with packet-safe config and stats.
module net_rate_limiter
    import net_pkg::*;
#(
    parameter int unsigned DATA_W = NET_DATA_W,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned CNT_W  = NET_CNT_W,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    input  logic [CNT_W-1:0]  rlimit_inc,
    input  logic [CNT_W-1:0]  rlimit_period,
    input  logic [CNT_W-1:0]  rlimit_size,
    output logic [STAT_W-1:0] pkt_count,
    output logic [STAT_W-1:0] flit_count,
    output logic [STAT_W-1:0] stall_count
);

    limiter_state_e    r_state;
    limiter_state_e    w_state_next;
    logic [CNT_W-1:0]  r_shadow_inc;
    logic [CNT_W-1:0]  r_shadow_period;
    logic [CNT_W-1:0]  r_shadow_size;
    logic [STAT_W-1:0] r_pkt_count;
    logic [STAT_W-1:0] r_flit_count;
    logic [STAT_W-1:0] r_stall_count;
    logic              w_tokens_nonzero;
    logic              w_xfer;
    logic              w_hold;

    assign out_data  = in_data;
    assign out_keep  = in_keep;
    assign out_last  = in_last;
    assign out_valid = in_valid && w_tokens_nonzero;
    assign in_ready  = out_ready && w_tokens_nonzero;
    assign w_xfer    = in_valid && in_ready;

    // A zero-size or zero-increment bucket stays empty and blocks traffic.
    assign w_hold = (r_shadow_size == '0) || (r_shadow_inc == '0);

    net_token_bucket #(
        .CNT_W (CNT_W)
    ) u_bucket (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_inc            (r_shadow_inc),
        .i_period         (r_shadow_period),
        .i_size           (r_shadow_size),
        .i_consume        (w_xfer),
        .i_hold           (w_hold),
        .o_tokens_nonzero (w_tokens_nonzero)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_xfer && !in_last) w_state_next = StInPkt;
            StInPkt: if (w_xfer && in_last)  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Settings only track the inputs between packets.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow_inc    <= '0;
            r_shadow_period <= '0;
            r_shadow_size   <= '0;
        end else if (r_state == StIdle) begin
            r_shadow_inc    <= rlimit_inc;
            r_shadow_period <= rlimit_period;
            r_shadow_size   <= rlimit_size;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_count   <= '0;
            r_flit_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_xfer) begin
                r_flit_count <= r_flit_count + 1'b1;
            end
            if (w_xfer && in_last) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (in_valid && !w_tokens_nonzero) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign pkt_count   = r_pkt_count;
    assign flit_count  = r_flit_count;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_net_rate_limiter.sv
// Self-checking bench for net_rate_limiter against a cycle-level token-bucket model.
module tb_net_rate_limiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_keep;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic [7:0]  rlimit_inc;
    logic [7:0]  rlimit_period;
    logic [7:0]  rlimit_size;
    logic [31:0] pkt_count;
    logic [31:0] flit_count;
    logic [31:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int          m_tokens, m_cnt, m_inc, m_period, m_size, m_in_pkt;
    int unsigned m_pkt, m_flit, m_stall;

    always #5 clock = ~clock;

    net_rate_limiter dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_keep       (in_keep),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last),
        .rlimit_inc    (rlimit_inc),
        .rlimit_period (rlimit_period),
        .rlimit_size   (rlimit_size),
        .pkt_count     (pkt_count),
        .flit_count    (flit_count),
        .stall_count   (stall_count)
    );

    function automatic logic [1:0] exp_hs();
        return {in_valid && (m_tokens != 0), out_ready && (m_tokens != 0)};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int n_tok, n_cnt, n_inc, n_per, n_size, n_pkt;
        int unsigned n_pc, n_fc, n_sc;
        bit xfer, refill;
        if (reset) begin
            n_tok = 0; n_cnt = 0; n_inc = 0; n_per = 0; n_size = 0; n_pkt = 0;
            n_pc = 0; n_fc = 0; n_sc = 0;
        end else begin
            xfer   = in_valid && out_ready && (m_tokens != 0);
            refill = (m_cnt == m_period);
            if (m_size == 0 || m_inc == 0) begin
                n_tok = 0;
            end else begin
                n_tok = m_tokens + (refill ? m_inc : 0) - (xfer ? 1 : 0);
                if (n_tok > m_size) n_tok = m_size;
            end
            n_cnt = refill ? 0 : (m_cnt + 1) % 256;
            n_fc  = m_flit + (xfer ? 1 : 0);
            n_pc  = m_pkt + ((xfer && in_last) ? 1 : 0);
            n_sc  = m_stall + ((in_valid && m_tokens == 0) ? 1 : 0);
            if (m_in_pkt == 0) begin
                n_inc = int'(rlimit_inc); n_per = int'(rlimit_period); n_size = int'(rlimit_size);
            end else begin
                n_inc = m_inc; n_per = m_period; n_size = m_size;
            end
            n_pkt = xfer ? (in_last ? 0 : 1) : m_in_pkt;
        end
        @(posedge clock);
        #1;
        m_tokens = n_tok; m_cnt = n_cnt; m_inc = n_inc; m_period = n_per; m_size = n_size;
        m_in_pkt = n_pkt; m_pkt = n_pc; m_flit = n_fc; m_stall = n_sc;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_cfg(input int i, input int p, input int s);
        rlimit_inc    = 8'(i);
        rlimit_period = 8'(p);
        rlimit_size   = 8'(s);
    endtask

    task automatic test_reset();
        set_cfg(3, 0, 8);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_last = 1'b0;
        in_data = rnd64(); in_keep = 8'hff;
        tick(); tick();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake got v=%b r=%b want 0 0", out_valid, in_ready);
        end
        checks++;
        if (pkt_count !== 32'd0 || flit_count !== 32'd0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", pkt_count, flit_count, stall_count);
        end
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_refill_every_cycle();
        int flits = 0;
        do_reset();
        set_cfg(1, 0, 8);
        out_ready = 1'b1;
        idle(1);
        in_valid = 1'b1; in_last = 1'b1;
        for (int c = 0; c < 24; c++) begin
            in_data = rnd64(); in_keep = 8'($urandom);
            #1;
            checks++;
            if ({out_valid, in_ready} !== exp_hs()) begin
                failures++;
                $display("FAIL every_cycle_hs c=%0d got=%b want=%b", c, {out_valid, in_ready}, exp_hs());
            end
            checks++;
            if (out_data !== in_data || out_keep !== in_keep || out_last !== in_last) begin
                failures++;
                $display("FAIL passthrough got %h/%h/%b want %h/%h/%b",
                         out_data, out_keep, out_last, in_data, in_keep, in_last);
            end
            if (c >= 4 && out_valid && out_ready) flits++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (flits != 20) begin
            failures++;
            $display("FAIL every_cycle_rate got %0d flits want 20", flits);
        end
        checks++;
        if (stall_count !== 32'd1 || stall_count !== m_stall) begin
            failures++;
            $display("FAIL every_cycle_stall got %0d want 1", stall_count);
        end
    endtask

    task automatic test_half_rate();
        int flits = 0, adj = 0;
        bit prev = 1'b0, f;
        do_reset();
        set_cfg(1, 1, 1);
        out_ready = 1'b1;
        idle(4);
        in_valid = 1'b1; in_last = 1'b1;
        for (int c = 0; c < 22; c++) begin
            in_data = rnd64();
            #1;
            checks++;
            if ({out_valid, in_ready} !== exp_hs()) begin
                failures++;
                $display("FAIL half_rate_hs c=%0d got=%b want=%b", c, {out_valid, in_ready}, exp_hs());
            end
            f = out_valid && out_ready;
            if (c >= 2) begin
                flits += int'(f);
                if (f && prev) adj++;
            end
            prev = f;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (flits != 10 || adj != 0) begin
            failures++;
            $display("FAIL half_rate got %0d flits %0d adjacent want 10 0", flits, adj);
        end
    endtask

    task automatic test_burst_throttle();
        int first = 0, late = 0;
        do_reset();
        set_cfg(1, 9, 4);
        out_ready = 1'b1;
        idle(50);
        in_valid = 1'b1; in_last = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_data = rnd64();
            #1;
            checks++;
            if ({out_valid, in_ready} !== exp_hs()) begin
                failures++;
                $display("FAIL burst_hs c=%0d got=%b want=%b", c, {out_valid, in_ready}, exp_hs());
            end
            if (out_valid && out_ready) begin
                if (c < 4) first++;
                if (c >= 10) late++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (first != 4 || late != 5) begin
            failures++;
            $display("FAIL burst_throttle got burst=%0d late=%0d want 4 5", first, late);
        end
    endtask

    task automatic test_mid_packet_cfg();
        int k = 0, t_first = -1, t_end1 = -1, t_start2 = -1, t_end2 = -1;
        do_reset();
        set_cfg(1, 0, 8);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = rnd64();
        for (int c = 0; c < 80 && k < 10; c++) begin
            in_last = (k == 5 || k == 9);
            #1;
            checks++;
            if ({out_valid, in_ready} !== exp_hs()) begin
                failures++;
                $display("FAIL midcfg_hs c=%0d got=%b want=%b", c, {out_valid, in_ready}, exp_hs());
            end
            if (out_valid && out_ready) begin
                if (k == 0) t_first = c;
                if (k == 5) t_end1 = c;
                if (k == 6) t_start2 = c;
                if (k == 9) t_end2 = c;
                k++;
                if (k == 2) rlimit_period = 8'd3;
            end
            tick();
            in_data = rnd64();
        end
        in_valid = 1'b0;
        checks++;
        if (k != 10 || t_end1 - t_first != 5) begin
            failures++;
            $display("FAIL midcfg_pkt1 got flits=%0d span=%0d want 10 5", k, t_end1 - t_first);
        end
        checks++;
        if (t_end2 - t_start2 < 8) begin
            failures++;
            $display("FAIL midcfg_pkt2 got span=%0d want >=8", t_end2 - t_start2);
        end
    endtask

    task automatic test_sim_refill_consume();
        int flits;
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            set_cfg(1, 0, 2);
            out_ready = 1'b1;
            idle(4);
            in_valid = 1'b1; in_last = 1'b1;
            flits = 0;
            for (int c = 0; c < 5; c++) begin
                #1;
                if (out_valid && out_ready) flits++;
                tick();
            end
            checks++;
            if (flits != 5) begin
                failures++;
                $display("FAIL steady_refill ph=%0d got %0d flits want 5", ph, flits);
            end
            set_cfg(1, 200, (ph == 0) ? 2 : 1);
            idle(3);
            in_valid = 1'b1;
            flits = 0;
            for (int c = 0; c < 8; c++) begin
                #1;
                checks++;
                if ({out_valid, in_ready} !== exp_hs()) begin
                    failures++;
                    $display("FAIL sat_hs ph=%0d c=%0d got=%b want=%b", ph, c, {out_valid, in_ready}, exp_hs());
                end
                if (out_valid && out_ready) flits++;
                tick();
            end
            in_valid = 1'b0;
            checks++;
            if (flits != ((ph == 0) ? 2 : 1)) begin
                failures++;
                $display("FAIL saturate ph=%0d got %0d tokens want %0d", ph, flits, (ph == 0) ? 2 : 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sizes[3] = '{3, 1, 5};
        logic [63:0] q[$];
        logic [63:0] want;
        int p = 0, k = 0;
        bit acc;
        do_reset();
        set_cfg(1, 0, 8);
        idle(2);
        for (int c = 0; c < 200 && p < 3; c++) begin
            out_ready = (c % 2 == 0);
            if (!in_valid) begin
                in_data = rnd64(); in_keep = 8'($urandom); in_last = (k == sizes[p] - 1);
                q.push_back(in_data);
                in_valid = 1'b1;
            end
            #1;
            checks++;
            if ({out_valid, in_ready} !== exp_hs()) begin
                failures++;
                $display("FAIL bp_hs c=%0d got=%b want=%b", c, {out_valid, in_ready}, exp_hs());
            end
            acc = out_valid && out_ready;
            if (acc) begin
                want = q.pop_front();
                checks++;
                if (out_data !== want) begin
                    failures++;
                    $display("FAIL bp_order got %h want %h", out_data, want);
                end
                if (in_last) begin p++; k = 0; end else k++;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (p != 3 || pkt_count !== 32'd3 || flit_count !== 32'd9 || stall_count !== m_stall) begin
            failures++;
            $display("FAIL bp_counters got pkts=%0d flits=%0d stall=%0d want 3 9 %0d",
                     pkt_count, flit_count, stall_count, m_stall);
        end
        // Reset in the middle of a packet.
        out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0; k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            in_data = rnd64();
            #1;
            if (out_valid && out_ready) k++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== 32'd0 || flit_count !== 32'd0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL midpkt_reset got v=%b %0d/%0d/%0d want 0 0/0/0",
                     out_valid, pkt_count, flit_count, stall_count);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        bit acc = 1'b1;
        do_reset();
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) set_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 6));
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rnd64();
                in_keep  = 8'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if ({out_valid, in_ready} !== exp_hs() || out_data !== in_data) begin
                failures++;
                $display("FAIL random_hs c=%0d got=%b want=%b", c, {out_valid, in_ready}, exp_hs());
            end
            acc = out_valid && out_ready;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (pkt_count !== m_pkt || flit_count !== m_flit || stall_count !== m_stall) begin
            failures++;
            $display("FAIL random_stats got %0d/%0d/%0d want %0d/%0d/%0d",
                     pkt_count, flit_count, stall_count, m_pkt, m_flit, m_stall);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
        in_data = '0; in_keep = '0;
        set_cfg(0, 0, 0);
        #2;
        test_reset();
        test_refill_every_cycle();
        test_half_rate();
        test_burst_throttle();
        test_mid_packet_cfg();
        test_sim_refill_consume();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
